// File: rtl/sti_seq_pkg.sv
// Shared state encoding, config-word field positions and burst-length helper
// for the STI_DAC load sequencer.
package sti_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_LOAD,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_e;

  localparam int CFG_LEN_HI = 13;
  localparam int CFG_LEN_LO = 12;
  localparam int CFG_FILL   = 8;
  localparam int CFG_MSB    = 4;
  localparam int CFG_LOW    = 0;

  // Serial bits per word implied by pi_length: 8/16/24/32.
  function automatic logic [5:0] exp_bits(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/sti_seq_watchdog.sv
// Cycles-since-load counter; expire rises on the (TIMEOUT_CYC-1)th enabled cycle
// after the clearing cycle, so the caller can leave on the TIMEOUT_CYC-th cycle.
module sti_seq_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The clearing (load) cycle counts as cycle 0, so the first wait cycle reads 1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CW'(1);
    end else if (en && (cnt_q != CW'(TIMEOUT_CYC - 1))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/sti_load_sequencer.sv
// Walks a command ROM and drives the STI_DAC parallel-load interface: start -> load in 3 cycles,
// so_valid fall -> next load in 3 cycles. Optional burst-length check under SO_LEN_CHECK_EN.
module sti_load_sequencer
  import sti_seq_pkg::*;
#(
  parameter int NUM_WORDS   = 100,
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_pattern,
  input  logic [15:0]       rom_config,
  output logic              load,
  output logic [15:0]       pi_data,
  output logic [1:0]        pi_length,
  output logic              pi_fill,
  output logic              pi_msb,
  output logic              pi_low,
  output logic              pi_end,
  input  logic              so_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_cnt,
  output logic              timeout_err,
  output logic              len_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic              pi_end_q, pi_end_d;
  logic              timeout_err_q, timeout_err_d;
  logic [15:0]       pi_data_q;
  logic [1:0]        pi_length_q;
  logic              pi_fill_q, pi_msb_q, pi_low_q;
  logic              start_acc, latch_en, last_word, wd_expire;
  logic              unused_cfg_bits;

  assign last_word       = (rom_addr_q == ADDR_W'(NUM_WORDS - 1));
  assign unused_cfg_bits = ^{rom_config[15:14], rom_config[11:9], rom_config[7:5], rom_config[3:1]};

  sti_seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q == S_LOAD),
    .en     (state_q == S_WAIT_HI),
    .expire (wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    rom_addr_d    = rom_addr_q;
    word_cnt_d    = word_cnt_q;
    pi_end_d      = pi_end_q;
    timeout_err_d = timeout_err_q;
    start_acc     = 1'b0;
    latch_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc     = 1'b1;
          rom_addr_d    = '0;
          word_cnt_d    = '0;
          timeout_err_d = 1'b0;
          state_d       = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        // pi_end is registered alongside pi_* so it is already high during the last load.
        latch_en = 1'b1;
        pi_end_d = last_word;
        state_d  = S_LOAD;
      end
      S_LOAD: state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (so_valid) begin
          state_d = S_WAIT_LO;
        end else if (wd_expire) begin
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_WAIT_LO: begin
        if (!so_valid) begin
          word_cnt_d = word_cnt_q + ADDR_W'(1);
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = S_FETCH;
          end
        end
      end
      S_DONE: begin
        pi_end_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rom_addr_q    <= '0;
      word_cnt_q    <= '0;
      pi_end_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      pi_data_q     <= '0;
      pi_length_q   <= '0;
      pi_fill_q     <= 1'b0;
      pi_msb_q      <= 1'b0;
      pi_low_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      word_cnt_q    <= word_cnt_d;
      pi_end_q      <= pi_end_d;
      timeout_err_q <= timeout_err_d;
      if (latch_en) begin
        pi_data_q   <= rom_pattern;
        pi_length_q <= rom_config[CFG_LEN_HI:CFG_LEN_LO];
        pi_fill_q   <= rom_config[CFG_FILL];
        pi_msb_q    <= rom_config[CFG_MSB];
        pi_low_q    <= rom_config[CFG_LOW];
      end
    end
  end

`ifdef SO_LEN_CHECK_EN
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic       len_err_q, len_err_d;

  // Counts every so_valid-high cycle of the word, including one seen on WAIT_HI entry.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    len_err_d = len_err_q;
    if (state_q == S_LOAD) begin
      bit_cnt_d = '0;
    end else if ((state_q == S_WAIT_HI || state_q == S_WAIT_LO) && so_valid && (bit_cnt_q != 6'h3f)) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
    end
    if (start_acc) begin
      len_err_d = 1'b0;
    end else if ((state_q == S_WAIT_LO) && !so_valid && (bit_cnt_q != exp_bits(pi_length_q))) begin
      len_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign len_err          = 1'b0;
`endif

  assign rom_rd      = (state_q == S_FETCH);
  assign load        = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign rom_addr    = rom_addr_q;
  assign word_cnt    = word_cnt_q;
  assign pi_end      = pi_end_q;
  assign timeout_err = timeout_err_q;
  assign pi_data     = pi_data_q;
  assign pi_length   = pi_length_q;
  assign pi_fill     = pi_fill_q;
  assign pi_msb      = pi_msb_q;
  assign pi_low      = pi_low_q;

endmodule

// File: tb/tb_sti_load_sequencer.sv
// Directed + randomized bench for sti_load_sequencer with a ROM model and so_valid stub.
module tb_sti_load_sequencer;

  localparam int NW = 3;
  localparam int AW = 7;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset, start, so_valid;
  logic          rom_rd, load, pi_fill, pi_msb, pi_low, pi_end, busy, done, timeout_err, len_err;
  logic [AW-1:0] rom_addr, word_cnt;
  logic [15:0]   rom_pattern = '0;
  logic [15:0]   rom_config  = '0;
  logic [15:0]   pi_data;
  logic [1:0]    pi_length;

  logic [15:0]   rom_pat_mem [NW];
  logic [15:0]   rom_cfg_mem [NW];
  int            burst [NW];
  int            gap   [NW];

  int errors = 0;
  int checks = 0;
  int hold   = 0;
  int done_seen = 0;

  sti_load_sequencer #(.NUM_WORDS(NW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_rd(rom_rd), .rom_addr(rom_addr),
    .rom_pattern(rom_pattern), .rom_config(rom_config), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low),
    .pi_end(pi_end), .so_valid(so_valid), .busy(busy), .done(done), .word_cnt(word_cnt),
    .timeout_err(timeout_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_rd === 1'b1) begin
      rom_pattern <= rom_pat_mem[rom_addr];
      rom_config  <= rom_cfg_mem[rom_addr];
    end
    if (done === 1'b1) done_seen <= done_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (hold > 0) begin
      hold--;
      if (hold == 0) start = 1'b0;
    end
  endtask

  task automatic randomize_rom();
    for (int w = 0; w < NW; w++) begin
      rom_pat_mem[w] = 16'($urandom);
      rom_cfg_mem[w] = 16'($urandom);
      burst[w] = 8 * (int'(rom_cfg_mem[w][13:12]) + 1);
      if ($urandom_range(0, 3) == 0) burst[w] = burst[w] + (($urandom_range(0, 1) == 1) ? 1 : -1);
      gap[w] = $urandom_range(0, 4);
    end
  endtask

  // Full run from IDLE; expectations come from the ROM tables and the burst plan.
  task automatic run_full();
    logic exp_len_err;
    exp_len_err = 1'b0;
    start = 1'b1;
    tick();
    if (hold == 0) start = 1'b0;
    chk("fetch_rd", 32'(rom_rd), 32'd1);
    chk("fetch_addr0", 32'(rom_addr), 32'd0);
    chk("start_clr_tmo", 32'(timeout_err), 32'd0);
    chk("start_clr_len", 32'(len_err), 32'd0);
    tick();
    chk("latch_no_load", 32'({rom_rd, load}), 32'd0);
    tick();
    for (int w = 0; w < NW; w++) begin
      chk("load", 32'(load), 32'd1);
      chk("pi_data", 32'(pi_data), 32'(rom_pat_mem[w]));
      chk("pi_length", 32'(pi_length), 32'(rom_cfg_mem[w][13:12]));
      chk("pi_flags", 32'({pi_fill, pi_msb, pi_low}),
          32'({rom_cfg_mem[w][8], rom_cfg_mem[w][4], rom_cfg_mem[w][0]}));
      chk("pi_end_at_load", 32'(pi_end), 32'(w == NW - 1));
      tick();
      chk("load_one_cycle", 32'(load), 32'd0);
      repeat (gap[w]) tick();
      so_valid = 1'b1;
      repeat (burst[w]) tick();
      so_valid = 1'b0;
`ifdef SO_LEN_CHECK_EN
      if (burst[w] != 8 * (int'(rom_cfg_mem[w][13:12]) + 1)) exp_len_err = 1'b1;
`endif
      tick();
      chk("word_cnt", 32'(word_cnt), 32'(w + 1));
      if (w < NW - 1) begin
        chk("next_rd", 32'(rom_rd), 32'd1);
        chk("next_addr", 32'(rom_addr), 32'(w + 1));
        tick();
        tick();
      end else begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("pi_end_in_done", 32'(pi_end), 32'd1);
        chk("len_err", 32'(len_err), 32'(exp_len_err));
        tick();
        chk("idle_state", 32'({busy, done, pi_end}), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    so_valid = 1'b0;
    repeat (2) tick();
    chk("rst_outs", 32'({rom_rd, load, pi_end, busy, done, timeout_err, len_err}), 32'd0);
    chk("rst_addr_cnt", 32'({rom_addr, word_cnt}), 32'd0);
    chk("rst_pi", 32'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 32'd0);
    reset = 1'b0;
    tick();

    // Three words with lengths 0/1/3 and exact bursts.
    rom_cfg_mem[0] = 16'h0000; rom_cfg_mem[1] = 16'h1000; rom_cfg_mem[2] = 16'h3111;
    rom_pat_mem[0] = 16'hA5A5; rom_pat_mem[1] = 16'h1234; rom_pat_mem[2] = 16'hFEDC;
    burst[0] = 8; burst[1] = 16; burst[2] = 32;
    gap[0] = 0; gap[1] = 2; gap[2] = 1;
    done_seen = 0;
    run_full();
    chk("one_done", 32'(done_seen), 32'd1);

    // so_valid never rises: abort exactly TO cycles after the load.
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    chk("tmo_load", 32'(load), 32'd1);
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk("tmo_latency", 32'(k), 32'(TO));
    chk("tmo_err", 32'(timeout_err), 32'd1);
    chk("tmo_word_cnt", 32'(word_cnt), 32'd0);
    tick();
    chk("tmo_sticky", 32'({busy, timeout_err}), 32'd1);
    tick();

    // Reset during WAIT_LO of word 1, then replay from address 0.
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    tick(); so_valid = 1'b1; repeat (8) tick(); so_valid = 1'b0;
    tick(); tick(); tick();
    chk("w1_load", 32'(load), 32'd1);
    tick(); so_valid = 1'b1; tick(); tick();
    chk("w1_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_outs", 32'({rom_rd, load, pi_end, busy, done, timeout_err, len_err}), 32'd0);
    chk("async_rst_addr", 32'({rom_addr, word_cnt}), 32'd0);
    so_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    randomize_rom();
    run_full();

    // Start held high for 20 cycles across a run.
    randomize_rom();
    done_seen = 0;
    hold = 20;
    run_full();
    repeat (25) tick();
    chk("held_start_one_done", 32'(done_seen), 32'd1);
    chk("held_start_idle", 32'(busy), 32'd0);

    // Short burst on pi_length=1; run must still complete.
    for (int w = 0; w < NW; w++) begin
      rom_cfg_mem[w] = 16'h1000;
      rom_pat_mem[w] = 16'(w * 16'h1111);
      burst[w] = (w == 0) ? 15 : 16;
      gap[w] = 0;
    end
    run_full();

    for (int r = 0; r < 4; r++) begin
      randomize_rom();
      run_full();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
